// File: rtl/data_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_pkg
// Shared constants and types for the two-master data bus arbiter:
//   - FSM state encoding (IDLE / ACCESS / RESPOND)
//   - bus access format codes (RISC-V funct3 load/store encoding)
//   - one-hot grant codes produced by rr_arbiter_2
//   - request_t: the payload latched from the granted master
// -----------------------------------------------------------------------------
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Access formats, funct3 encoding. Stores use the same codes as loads.
    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    // One-hot grant vector: bit 0 = M0, bit 1 = M1.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] write_data;
        logic [2:0]  format;
        logic        write;
    } request_t;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter_if
// Bundles both master ports and the slave-side bus of the arbiter.
//   modport slave  : the arbiter's view (serves the masters, drives the bus)
//   modport master : the environment's view (masters plus the memory slave)
// Signals:
//   mX_request/address/write_data/format/write  master request + payload
//   mX_ack/error/read_data                      one-cycle completion to master
//   bus_address/write_data/format               slave payload
//   bus_read_enable/bus_write_enable            slave strobes
//   bus_data_fetched/bus_ready                  slave response
// -----------------------------------------------------------------------------
interface data_bus_arbiter_if;

    logic        m0_request;
    logic [31:0] m0_address;
    logic [31:0] m0_write_data;
    logic [2:0]  m0_format;
    logic        m0_write;
    logic        m0_ack;
    logic        m0_error;
    logic [31:0] m0_read_data;

    logic        m1_request;
    logic [31:0] m1_address;
    logic [31:0] m1_write_data;
    logic [2:0]  m1_format;
    logic        m1_write;
    logic        m1_ack;
    logic        m1_error;
    logic [31:0] m1_read_data;

    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [2:0]  bus_format;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_data_fetched;
    logic        bus_ready;

    modport slave (
        input  m0_request, m0_address, m0_write_data, m0_format, m0_write,
        output m0_ack, m0_error, m0_read_data,
        input  m1_request, m1_address, m1_write_data, m1_format, m1_write,
        output m1_ack, m1_error, m1_read_data,
        output bus_address, bus_write_data, bus_format,
        output bus_read_enable, bus_write_enable,
        input  bus_data_fetched, bus_ready
    );

    modport master (
        output m0_request, m0_address, m0_write_data, m0_format, m0_write,
        input  m0_ack, m0_error, m0_read_data,
        output m1_request, m1_address, m1_write_data, m1_format, m1_write,
        input  m1_ack, m1_error, m1_read_data,
        input  bus_address, bus_write_data, bus_format,
        input  bus_read_enable, bus_write_enable,
        output bus_data_fetched, bus_ready
    );

endinterface

// File: rtl/data_bus_arbiter_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-way round-robin pick.
//   request[1:0]  in   request[0] = M0, request[1] = M1
//   last_grant    in   index of the master served most recently
//   grant[1:0]    out  one-hot grant, 00 when nobody requests
// A lone requester always wins; on a tie the master not served last wins.
// -----------------------------------------------------------------------------
module rr_arbiter_2
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] request,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives grant;
        // a missing assignment in always_comb would infer a latch.
        grant = GRANT_NONE;
        case (request)
            2'b01:   grant = GRANT_M0;
            2'b10:   grant = GRANT_M1;
            2'b11:   grant = last_grant ? GRANT_M0 : GRANT_M1;
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
// Shares one data-memory slave port between M0 (core load/store) and M1
// (debug loader / DMA). One transfer in flight at a time, round-robin on ties,
// and a timeout that completes a transfer with an error if the slave never
// raises bus_ready.
//   clock  in  single clock, all state on the rising edge
//   reset  in  synchronous, active-low
//   port   arbiter side (slave modport) of data_bus_arbiter_if
// Transfer: IDLE (grant, latch payload) -> ACCESS (strobe held until ready or
// timeout) -> RESPOND (one-cycle ack to the granted master) -> IDLE.
// -----------------------------------------------------------------------------
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,  // 0 disables the timeout
    parameter int TIMER_WIDTH    = 8
)(
    input  logic               clock,
    input  logic               reset,
    data_bus_arbiter_if.slave  port
);

    localparam bit                     TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST     = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic                   last_grant;   // 0 = M0, 1 = M1; also the master in flight
    logic [TIMER_WIDTH-1:0] timer;
    logic [1:0]             grant;
    request_t               req0, req1, sel;
    logic                   timeout_hit;
    logic [31:0]            resp_data;
    logic                   resp_error;

    assign req0 = '{address: port.m0_address, write_data: port.m0_write_data,
                    format: port.m0_format, write: port.m0_write};
    assign req1 = '{address: port.m1_address, write_data: port.m1_write_data,
                    format: port.m1_format, write: port.m1_write};

    rr_arbiter_2 u_rr_arbiter_2 (
        .request    ({port.m1_request, port.m0_request}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        sel = req0;
        if (grant[1]) sel = req1;
    end

    // A ready slave wins over a timeout landing in the same cycle.
    assign timeout_hit = TIMEOUT_ENABLE && (timer == TIMER_LAST);
    assign resp_error  = !port.bus_ready;
    assign resp_data   = port.bus_ready ? port.bus_data_fetched : 32'd0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state                 <= IDLE;
            last_grant            <= 1'b1;     // M0 wins the first tie
            timer                 <= '0;
            port.m0_ack           <= 1'b0;
            port.m0_error         <= 1'b0;
            port.m0_read_data     <= '0;
            port.m1_ack           <= 1'b0;
            port.m1_error         <= 1'b0;
            port.m1_read_data     <= '0;
            port.bus_address      <= '0;
            port.bus_write_data   <= '0;
            port.bus_format       <= '0;
            port.bus_read_enable  <= 1'b0;
            port.bus_write_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != GRANT_NONE) begin
                        last_grant            <= grant[1];
                        port.bus_address      <= sel.address;
                        port.bus_write_data   <= sel.write_data;
                        port.bus_format       <= sel.format;
                        port.bus_write_enable <= sel.write;
                        port.bus_read_enable  <= !sel.write;
                        timer                 <= '0;
                        state                 <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (port.bus_ready || timeout_hit) begin
                        port.bus_read_enable  <= 1'b0;
                        port.bus_write_enable <= 1'b0;
                        if (last_grant) begin
                            port.m1_ack       <= 1'b1;
                            port.m1_error     <= resp_error;
                            port.m1_read_data <= resp_data;
                        end else begin
                            port.m0_ack       <= 1'b1;
                            port.m0_error     <= resp_error;
                            port.m0_read_data <= resp_data;
                        end
                        state <= RESPOND;
                    end else if (timer != '1) begin
                        // Saturate rather than wrap when the timeout is disabled.
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end

                RESPOND: begin
                    // Completion outputs live for this single cycle only; the
                    // bus payload stays put until the next grant.
                    port.m0_ack       <= 1'b0;
                    port.m0_error     <= 1'b0;
                    port.m0_read_data <= '0;
                    port.m1_ack       <= 1'b0;
                    port.m1_error     <= 1'b0;
                    port.m1_read_data <= '0;
                    state             <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
// Table of complete transfers (requests, slave behaviour, expected grant,
// strobes, completion), followed by hand-written sequences for reset in the
// middle of ACCESS and a payload change after grant. Inputs are driven and
// outputs sampled on the falling edge. The DUT uses TIMEOUT_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int NVEC    = 12;

    typedef struct {
        bit          rst;
        bit          m0_req;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic [2:0]  m0_fmt;
        bit          m0_wr;
        bit          m1_req;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [2:0]  m1_fmt;
        bit          m1_wr;
        int          ready_cycle;  // ACCESS cycle (1-based) with bus_ready high; 0 = never
        logic [31:0] slave_data;
        bit          exp_grant;    // 0 = M0, 1 = M1
        logic [31:0] exp_addr;
        bit          exp_wr;
        int          exp_strobes;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_gap;      // cycles since previous ack; 0 = not checked
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_ack_cycle = 0;
    vec_t vecs [NVEC];

    data_bus_arbiter_if ifc ();

    data_bus_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .TIMER_WIDTH    (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .port  (ifc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        ifc.m0_request       = 1'b0;
        ifc.m0_address       = '0;
        ifc.m0_write_data    = '0;
        ifc.m0_format        = '0;
        ifc.m0_write         = 1'b0;
        ifc.m1_request       = 1'b0;
        ifc.m1_address       = '0;
        ifc.m1_write_data    = '0;
        ifc.m1_format        = '0;
        ifc.m1_write         = 1'b0;
        ifc.bus_ready        = 1'b0;
        ifc.bus_data_fetched = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack_err"}, 32'({ifc.m1_error, ifc.m0_error, ifc.m1_ack, ifc.m0_ack}), 32'd0);
        check({tag, "_m0_rdata"}, ifc.m0_read_data, 32'd0);
        check({tag, "_m1_rdata"}, ifc.m1_read_data, 32'd0);
        check({tag, "_strobes"}, 32'({ifc.bus_read_enable, ifc.bus_write_enable}), 32'd0);
        check({tag, "_bus_addr"}, ifc.bus_address, 32'd0);
        check({tag, "_bus_wdata"}, ifc.bus_write_data, 32'd0);
        check({tag, "_bus_fmt"}, 32'(ifc.bus_format), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        drive_idle();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero({tag, "_rst"});
        reset = 1'b1;
    endtask

    // Returns at the falling edge of the first ACCESS cycle (bounded wait).
    task automatic wait_strobe(input string name);
        int waited = 0;
        do begin
            @(posedge clock);
            @(negedge clock);
            waited++;
        end while (!(ifc.bus_read_enable || ifc.bus_write_enable) && waited < 8);
        check({name, "_strobe_seen"}, 32'(ifc.bus_read_enable | ifc.bus_write_enable), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string       n = $sformatf("v%0d", idx);
        int          strobes = 0;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_fmt;

        if (v.rst) apply_reset(n);
        ifc.m0_request    = v.m0_req;
        ifc.m0_address    = v.m0_addr;
        ifc.m0_write_data = v.m0_wdata;
        ifc.m0_format     = v.m0_fmt;
        ifc.m0_write      = v.m0_wr;
        ifc.m1_request    = v.m1_req;
        ifc.m1_address    = v.m1_addr;
        ifc.m1_write_data = v.m1_wdata;
        ifc.m1_format     = v.m1_fmt;
        ifc.m1_write      = v.m1_wr;
        ifc.bus_ready     = 1'b0;
        exp_wdata = v.exp_grant ? v.m1_wdata : v.m0_wdata;
        exp_fmt   = v.exp_grant ? v.m1_fmt   : v.m0_fmt;

        wait_strobe(n);
        check({n, "_rd_en"}, 32'(ifc.bus_read_enable), 32'(!v.exp_wr));
        check({n, "_wr_en"}, 32'(ifc.bus_write_enable), 32'(v.exp_wr));
        check({n, "_addr"}, ifc.bus_address, v.exp_addr);
        check({n, "_fmt"}, 32'(ifc.bus_format), 32'(exp_fmt));
        if (v.exp_wr) check({n, "_wdata"}, ifc.bus_write_data, exp_wdata);

        while ((ifc.bus_read_enable || ifc.bus_write_enable) && strobes < 10) begin
            strobes++;
            ifc.bus_ready        = (strobes == v.ready_cycle);
            ifc.bus_data_fetched = v.slave_data;
            @(posedge clock);
            @(negedge clock);
        end
        ifc.bus_ready = 1'b0;

        // Now in RESPOND.
        check({n, "_strobe_cycles"}, 32'(strobes), 32'(v.exp_strobes));
        check({n, "_acks"}, 32'({ifc.m1_ack, ifc.m0_ack}), v.exp_grant ? 32'd2 : 32'd1);
        if (v.exp_grant) begin
            check({n, "_m1_rdata"}, ifc.m1_read_data, v.exp_rdata);
            check({n, "_m1_err"}, 32'(ifc.m1_error), 32'(v.exp_err));
            check({n, "_m0_idle"}, 32'({ifc.m0_error, |ifc.m0_read_data}), 32'd0);
        end else begin
            check({n, "_m0_rdata"}, ifc.m0_read_data, v.exp_rdata);
            check({n, "_m0_err"}, 32'(ifc.m0_error), 32'(v.exp_err));
            check({n, "_m1_idle"}, 32'({ifc.m1_error, |ifc.m1_read_data}), 32'd0);
        end
        if (v.exp_gap != 0) check({n, "_ack_gap"}, 32'(cycle - last_ack_cycle), 32'(v.exp_gap));
        last_ack_cycle = cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst | m0: req addr wdata fmt wr | m1: req addr wdata fmt wr | rdy data | grant addr wr strobes rdata err gap
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h0, FMT_W, 1'b0, 1'b0, 32'h0, 32'h0, FMT_W, 1'b0,
                     2, 32'hDEAD_BEEF, 1'b0, 32'h0000_2000, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 32'h10, 32'h11, FMT_W, 1'b1, 1'b1, 32'h20, 32'h0, FMT_W, 1'b0,
                     1, 32'h0, 1'b0, 32'h10, 1'b1, 1, 32'h0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 32'h10, 32'h11, FMT_W, 1'b1, 1'b1, 32'h20, 32'h0, FMT_W, 1'b0,
                     1, 32'h1234_5678, 1'b1, 32'h20, 1'b0, 1, 32'h1234_5678, 1'b0, 3};
        vecs[3]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     1, 32'hA5, 1'b0, 32'h100, 1'b0, 1, 32'hA5, 1'b0, 3};
        vecs[4]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     2, 32'h0, 1'b1, 32'h200, 1'b1, 2, 32'h0, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     3, 32'hFF, 1'b0, 32'h100, 1'b0, 3, 32'hFF, 1'b0, 5};
        vecs[6]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     1, 32'h0, 1'b1, 32'h200, 1'b1, 1, 32'h0, 1'b0, 3};
        vecs[7]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     2, 32'h7E, 1'b0, 32'h100, 1'b0, 2, 32'h7E, 1'b0, 4};
        vecs[8]  = '{1'b0, 1'b1, 32'h100, 32'h0, FMT_BU, 1'b0, 1'b1, 32'h200, 32'hCAFE, FMT_B, 1'b1,
                     4, 32'h0, 1'b1, 32'h200, 1'b1, 4, 32'h0, 1'b0, 6};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, FMT_W, 1'b0, 1'b1, 32'h300, 32'h0, FMT_HU, 1'b0,
                     0, 32'hFFFF_FFFF, 1'b1, 32'h300, 1'b0, TIMEOUT, 32'h0, 1'b1, 6};
        vecs[10] = '{1'b0, 1'b1, 32'h400, 32'h0, FMT_H, 1'b0, 1'b1, 32'h500, 32'h0, FMT_W, 1'b0,
                     1, 32'h0BAD_F00D, 1'b0, 32'h400, 1'b0, 1, 32'h0BAD_F00D, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b1, 32'h400, 32'h0, FMT_H, 1'b0, 1'b1, 32'h500, 32'h0, FMT_W, 1'b0,
                     1, 32'h600D_CAFE, 1'b1, 32'h500, 1'b0, 1, 32'h600D_CAFE, 1'b0, 3};

        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset during the second ACCESS cycle of an M1 read.
        drive_idle();
        ifc.m1_request = 1'b1;
        ifc.m1_address = 32'h600;
        ifc.m1_format  = FMT_W;
        wait_strobe("mid_rst");
        check("mid_rst_addr", ifc.bus_address, 32'h600);
        @(posedge clock);
        @(negedge clock);
        reset          = 1'b0;
        ifc.m0_request = 1'b1;
        ifc.m0_address = 32'h700;
        ifc.m0_format  = FMT_W;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("mid_rst");
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_regrant_addr", ifc.bus_address, 32'h700);
        check("mid_rst_regrant_rd", 32'(ifc.bus_read_enable), 32'd1);
        check("mid_rst_no_ack", 32'({ifc.m1_ack, ifc.m0_ack}), 32'd0);
        ifc.bus_ready        = 1'b1;
        ifc.bus_data_fetched = 32'h77;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_acks", 32'({ifc.m1_ack, ifc.m0_ack}), 32'd1);
        check("mid_rst_m0_rdata", ifc.m0_read_data, 32'h77);

        // Payload change one cycle after grant must not reach the bus.
        drive_idle();
        ifc.m0_request = 1'b1;
        ifc.m0_address = 32'h40;
        ifc.m0_format  = FMT_W;
        wait_strobe("payload");
        ifc.m0_address = 32'h80;
        check("payload_access1_addr", ifc.bus_address, 32'h40);
        @(posedge clock);
        @(negedge clock);
        check("payload_access2_addr", ifc.bus_address, 32'h40);
        check("payload_access2_rd", 32'(ifc.bus_read_enable), 32'd1);
        ifc.bus_ready        = 1'b1;
        ifc.bus_data_fetched = 32'h4040_4040;
        @(posedge clock);
        @(negedge clock);
        check("payload_respond_addr", ifc.bus_address, 32'h40);
        check("payload_ack", 32'({ifc.m1_ack, ifc.m0_ack}), 32'd1);
        check("payload_rdata", ifc.m0_read_data, 32'h4040_4040);
        drive_idle();
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            check("idle_no_strobe", 32'({ifc.bus_read_enable, ifc.bus_write_enable}), 32'd0);
            check("idle_no_ack", 32'({ifc.m1_ack, ifc.m0_ack}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
